// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, field positions, default widths and
// immediate-format classification used by decode and execute.
package rv32_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int NREG_BITS_DEF = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            OP_REG:                   return FMT_R;
            default:                  return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/operand_fetch_imm_gen.sv
// RV32I immediate generator: decodes the format from the opcode and returns
// the sign-extended immediate (zero for R-type and unknown opcodes).
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt_of(instr_i[OPC_MSB:OPC_LSB]))
            FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm32 = {instr_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage with valid/ready output register.
// OPFETCH_BYPASS_EN enables EX/WB forwarding; otherwise any RAW match stalls.
module operand_fetch
    import rv32_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREG_BITS = NREG_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic [NREG_BITS-1:0] ra1,
    output logic [NREG_BITS-1:0] ra2,
    input  logic [XLEN-1:0]      rd1,
    input  logic [XLEN-1:0]      rd2,
    input  logic                 ex_valid,
    input  logic                 ex_we,
    input  logic                 ex_is_load,
    input  logic [NREG_BITS-1:0] ex_wa,
    input  logic [XLEN-1:0]      ex_wd,
    input  logic                 wb_we,
    input  logic [NREG_BITS-1:0] wb_wa,
    input  logic [XLEN-1:0]      wb_wd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_instr,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [XLEN-1:0]      out_imm,
    output logic [NREG_BITS-1:0] out_rd
);

    logic [6:0]           opc;
    logic [NREG_BITS-1:0] rs1;
    logic [NREG_BITS-1:0] rs2;
    logic [NREG_BITS-1:0] rd_dec;
    logic                 use1;
    logic                 use2;
    logic                 ex_hit1;
    logic                 ex_hit2;
    logic                 wb_hit1;
    logic                 wb_hit2;
    logic                 hazard;
    logic                 capture;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [XLEN-1:0]      imm;

    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      pc_q,    pc_d;
    logic [31:0]          instr_q, instr_d;
    logic [XLEN-1:0]      op1_q,   op1_d;
    logic [XLEN-1:0]      op2_q,   op2_d;
    logic [XLEN-1:0]      imm_q,   imm_d;
    logic [NREG_BITS-1:0] rd_q,    rd_d;

    assign opc = in_instr[OPC_MSB:OPC_LSB];
    assign rs1 = NREG_BITS'(in_instr[RS1_MSB:RS1_LSB]);
    assign rs2 = NREG_BITS'(in_instr[RS2_MSB:RS2_LSB]);
    assign ra1 = rs1;
    assign ra2 = rs2;

    assign use1   = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign use2   = (opc == OP_REG || opc == OP_STORE || opc == OP_BRANCH);
    assign rd_dec = (opc == OP_STORE || opc == OP_BRANCH) ? '0
                                                          : NREG_BITS'(in_instr[RD_MSB:RD_LSB]);

    assign ex_hit1 = ex_valid && ex_we && (ex_wa == rs1);
    assign ex_hit2 = ex_valid && ex_we && (ex_wa == rs2);
    assign wb_hit1 = wb_we && (wb_wa == rs1);
    assign wb_hit2 = wb_we && (wb_wa == rs2);

`ifdef OPFETCH_BYPASS_EN
    // A load in EX has no data yet, so it stalls instead of forwarding.
    always_comb begin
        op1 = rd1;
        if (rs1 == '0)                  op1 = '0;
        else if (ex_hit1 && !ex_is_load) op1 = ex_wd;
        else if (wb_hit1)               op1 = wb_wd;

        op2 = rd2;
        if (rs2 == '0)                  op2 = '0;
        else if (ex_hit2 && !ex_is_load) op2 = ex_wd;
        else if (wb_hit2)               op2 = wb_wd;
    end

    assign hazard = ex_is_load && (ex_wa != '0) &&
                    ((use1 && ex_hit1) || (use2 && ex_hit2));
`else
    logic unused_bypass;
    assign unused_bypass = ^{ex_wd, wb_wd, ex_is_load};

    assign op1 = (rs1 == '0) ? '0 : rd1;
    assign op2 = (rs2 == '0) ? '0 : rd2;

    assign hazard = (use1 && (rs1 != '0) && (ex_hit1 || wb_hit1)) ||
                    (use2 && (rs2 != '0) && (ex_hit2 || wb_hit2));
`endif

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm)
    );

    assign in_ready = !hazard && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        imm_d   = imm_q;
        rd_d    = rd_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
            op1_d   = op1;
            op2_d   = op2;
            imm_d   = imm;
            rd_d    = rd_dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_imm   = imm_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vectors, a spec-level model checked every
// cycle, and literal expectations; follows the OPFETCH_BYPASS_EN build.
module tb_operand_fetch;
    import rv32_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        ex_valid, ex_we, ex_is_load;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr, out_op1, out_op2, out_imm;
    logic [4:0]  out_rd;

    int errors = 0;
    int checks = 0;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_wa(ex_wa), .ex_wd(ex_wd),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_op1(out_op1),
        .out_op2(out_op2), .out_imm(out_imm), .out_rd(out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_use1(input logic [31:0] i);
        return !(i[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic bit m_use2(input logic [31:0] i);
        return i[6:0] inside {OP_REG, OP_STORE, OP_BRANCH};
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        case (i[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin s12 = i[31:20];                   return 32'(s12); end
            OP_STORE:  begin s12 = {i[31:25], i[11:7]};                        return 32'(s12); end
            OP_BRANCH: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};    return 32'(s13); end
            OP_JAL:    begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};  return 32'(s21); end
            OP_LUI, OP_AUIPC: return {i[31:12], 12'h000};
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] a, input logic [31:0] rf_val);
        if (a == 5'd0) return 32'h0;
`ifdef OPFETCH_BYPASS_EN
        if (ex_valid && ex_we && !ex_is_load && ex_wa == a) return ex_wd;
        if (wb_we && wb_wa == a) return wb_wd;
`endif
        return rf_val;
    endfunction

    function automatic bit m_hazard();
        logic [4:0] src [2];
        bit         used [2];
        bit         h;
        src[0] = in_instr[19:15]; used[0] = m_use1(in_instr);
        src[1] = in_instr[24:20]; used[1] = m_use2(in_instr);
        h = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (used[k] && src[k] != 5'd0) begin
`ifdef OPFETCH_BYPASS_EN
                if (ex_valid && ex_we && ex_is_load && ex_wa == src[k]) h = 1'b1;
`else
                if ((ex_valid && ex_we && ex_wa == src[k]) || (wb_we && wb_wa == src[k])) h = 1'b1;
`endif
            end
        end
        return h;
    endfunction

    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr, exp_op1, exp_op2, exp_imm;
    logic [4:0]  exp_rd;
    bit          exp_use1, exp_use2;

    function automatic bit m_ready();
        return !m_hazard() && (!exp_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_pc <= '0; exp_instr <= '0; exp_op1 <= '0; exp_op2 <= '0;
            exp_imm <= '0; exp_rd <= '0; exp_use1 <= 1'b0; exp_use2 <= 1'b0;
        end else if (flush) begin
            exp_valid <= 1'b0;
        end else if (in_valid && m_ready()) begin
            exp_valid <= 1'b1;
            exp_pc    <= in_pc;
            exp_instr <= in_instr;
            exp_op1   <= m_operand(in_instr[19:15], rd1);
            exp_op2   <= m_operand(in_instr[24:20], rd2);
            exp_imm   <= m_imm(in_instr);
            exp_rd    <= (in_instr[6:0] inside {OP_STORE, OP_BRANCH}) ? 5'd0 : in_instr[11:7];
            exp_use1  <= m_use1(in_instr);
            exp_use2  <= m_use2(in_instr);
        end else if (out_ready) begin
            exp_valid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("ra1", 32'(ra1), 32'(in_instr[19:15]));
        chk("ra2", 32'(ra2), 32'(in_instr[24:20]));
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, exp_instr);
            chk("out_imm", out_imm, exp_imm);
            chk("out_rd", 32'(out_rd), 32'(exp_rd));
            if (exp_use1) chk("out_op1", out_op1, exp_op1);
            if (exp_use2) chk("out_op2", out_op2, exp_op2);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_wa = 0; ex_wd = 0;
        wb_we = 0; wb_wa = 0; wb_wd = 0;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1; in_instr = instr; in_pc = pc;
    endtask

    localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADD6  = 32'h00028333; // add  x6,x5,x0
    localparam logic [31:0] I_SW    = 32'h0020A423; // sw   x2,8(x1)
    localparam logic [31:0] I_BEQ   = 32'hFE000CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_LUI   = 32'h123453B7; // lui  x7,0x12345
    localparam logic [31:0] I_JAL   = 32'h010000EF; // jal  x1,16

    initial begin
        rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; rd1 = 0; rd2 = 0;
        flush = 0; out_ready = 1;
        clear_fwd();
        #1 chk("reset_valid", 32'(out_valid), 32'h0);
        cyc(); cyc();
        rst_n = 1;

        // capture, then asynchronous reset mid-stream
        offer(I_LUI, 32'h40);
        cyc();
        chk("lui_valid", 32'(out_valid), 32'h1);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", 32'(out_rd), 32'd7);
        rst_n = 0;
        #2;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_pc", out_pc, 32'h0);
        in_valid = 0;
        #1 rst_n = 1;

        offer(I_ADDI, 32'h44);
        cyc();
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_op1", out_op1, 32'h0);
        chk("addi_imm", out_imm, 32'd5);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_pc", out_pc, 32'h44);

        // EX forwards rs1, WB forwards rs2
        offer(I_ADD3, 32'h48);
        rd1 = 32'hDEAD; rd2 = 32'hDEAD;
        ex_valid = 1; ex_we = 1; ex_wa = 1; ex_wd = 32'h11;
        wb_we = 1; wb_wa = 2; wb_wd = 32'h22;
`ifdef OPFETCH_BYPASS_EN
        cyc();
        chk("fwd_op1", out_op1, 32'h11);
        chk("fwd_op2", out_op2, 32'h22);
        chk("fwd_rd", 32'(out_rd), 32'd3);
`else
        #1 chk("nobyp_stall", 32'(in_ready), 32'h0);
        cyc(); cyc();
        clear_fwd();
        #1 chk("nobyp_release", 32'(in_ready), 32'h1);
        cyc();
        chk("nobyp_op1", out_op1, 32'hDEAD);
        chk("nobyp_op2", out_op2, 32'hDEAD);
`endif

        // EX and WB both target x1: EX wins
        offer(I_ADD3, 32'h4C);
        rd2 = 32'h55;
        ex_valid = 1; ex_we = 1; ex_wa = 1; ex_wd = 32'hA;
        wb_we = 1; wb_wa = 1; wb_wd = 32'hB;
`ifdef OPFETCH_BYPASS_EN
        cyc();
        chk("prio_op1", out_op1, 32'hA);
        chk("prio_op2", out_op2, 32'h55);
`else
        #1 chk("nobyp_prio_stall", 32'(in_ready), 32'h0);
        cyc();
        clear_fwd();
        cyc();
        chk("nobyp_prio_op1", out_op1, 32'hDEAD);
`endif
        clear_fwd();

        // load-use stall for as long as ex_valid holds
        offer(I_ADD6, 32'h5C);
        rd1 = 32'h1234;
        ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_wa = 5; ex_wd = 32'h99;
        for (int k = 0; k < 3; k++) begin
            #1 chk("load_use_stall", 32'(in_ready), 32'h0);
            cyc();
        end
        ex_valid = 0;
        wb_we = 1; wb_wa = 5; wb_wd = 32'h77;
`ifdef OPFETCH_BYPASS_EN
        #1 chk("load_use_release", 32'(in_ready), 32'h1);
        cyc();
        chk("load_use_op1", out_op1, 32'h77);
        chk("load_use_op2", out_op2, 32'h0);
`else
        #1 chk("nobyp_wb_stall", 32'(in_ready), 32'h0);
        cyc();
        wb_we = 0;
        cyc();
        chk("nobyp_lu_op1", out_op1, 32'h1234);
        chk("nobyp_lu_op2", out_op2, 32'h0);
`endif
        clear_fwd();

        // backpressure hold, then back-to-back capture
        out_ready = 0;
        offer(I_SW, 32'h60);
        rd1 = 32'h1; rd2 = 32'h2;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_ready", 32'(in_ready), 32'h0);
            chk("hold_rd", 32'(out_rd), 32'd6);
            chk("hold_pc", out_pc, 32'h5C);
            cyc();
        end
        out_ready = 1;
        #1 chk("hold_release", 32'(in_ready), 32'h1);
        cyc();
        chk("b2b_valid", 32'(out_valid), 32'h1);
        chk("store_rd", 32'(out_rd), 32'd0);
        chk("store_imm", out_imm, 32'd8);
        chk("store_pc", out_pc, 32'h60);

        offer(I_BEQ, 32'h64);
        cyc();
        chk("branch_imm", out_imm, 32'hFFFFFFF8);
        chk("branch_rd", 32'(out_rd), 32'd0);

        // flush drops the offered instruction
        offer(I_LUI, 32'h68);
        flush = 1;
        #1 chk("flush_ready", 32'(in_ready), 32'h1);
        cyc();
        chk("flush_valid", 32'(out_valid), 32'h0);
        flush = 0; in_valid = 0;
        cyc(); cyc();
        chk("flush_dropped", 32'(out_valid), 32'h0);

        // flush dominates hold
        offer(I_ADDI, 32'h70);
        cyc();
        out_ready = 0;
        offer(I_JAL, 32'h74);
        cyc();
        chk("pre_flush_hold", out_pc, 32'h70);
        flush = 1;
        cyc();
        chk("flush_hold_valid", 32'(out_valid), 32'h0);
        flush = 0; out_ready = 1;
        cyc();
        chk("jal_valid", 32'(out_valid), 32'h1);
        chk("jal_imm", out_imm, 32'd16);
        chk("jal_rd", 32'(out_rd), 32'd1);

        // flush together with a load-use hazard
        offer(I_ADD6, 32'h78);
        ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_wa = 5;
        flush = 1;
        #1 chk("flush_hz_ready", 32'(in_ready), 32'h0);
        cyc();
        chk("flush_hz_valid", 32'(out_valid), 32'h0);
        flush = 0; in_valid = 0;
        clear_fwd();
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch pipeline stage directly upstream of the register file.
- Drives the regfile read addresses from the incoming instruction and consumes the two read data words.
- Resolves RAW hazards by bypassing from the EX and WB stages, or by stalling on load-use.
- Holds the result in a valid/ready pipeline register that feeds the execute stage.

Parameters:
XLEN, 32, datapath and PC width.
NREG_BITS, 5, register index width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  RV32I instruction word
in_pc  in  XLEN  instruction PC
ra1  out  NREG_BITS  regfile read address 1 = in_instr[19:15]
ra2  out  NREG_BITS  regfile read address 2 = in_instr[24:20]
rd1  in  XLEN  regfile read data 1 (combinational)
rd2  in  XLEN  regfile read data 2 (combinational)
ex_valid  in  1  EX stage holds a live instruction
ex_we  in  1  EX instruction writes a register
ex_is_load  in  1  EX instruction is a load (result not yet available)
ex_wa  in  NREG_BITS  EX destination
ex_wd  in  XLEN  EX ALU result
wb_we  in  1  same signal driving the regfile we
wb_wa  in  NREG_BITS  same as regfile wa
wb_wd  in  XLEN  same as regfile wd
flush  in  1  kill held and incoming instruction (branch redirect)
out_valid  out  1  output register valid
out_ready  in  1  execute stage accepts
out_pc  out  XLEN  captured PC
out_instr  out  32  captured instruction
out_op1  out  XLEN  resolved rs1 value
out_op2  out  XLEN  resolved rs2 value
out_imm  out  XLEN  sign-extended immediate
out_rd  out  NREG_BITS  destination index (0 if the instruction does not write)

Behaviour:
- Reset (async, rst_n low): out_valid=0; all other out_* registers=0; takes effect immediately regardless of clk.
- ra1/ra2: purely combinational from in_instr; driven even when in_valid=0.
- Source usage, decoded from opcode:
  - rs1 used unless the opcode is LUI, AUIPC or JAL.
  - rs2 used only for R-type, STORE and BRANCH.
  - Unused sources never cause a hazard.
- Operand resolution, per used source s with index a:
  - a==0: value is 0, no forwarding.
  - Else if ex_valid && ex_we && ex_wa==a && !ex_is_load: ex_wd.
  - Else if wb_we && wb_wa==a: wb_wd. Required because the regfile writes on the clock edge, so the same-cycle read returns the old value.
  - Else: rd1/rd2.
  - EX has priority over WB.
- Load-use hazard: ex_valid && ex_we && ex_is_load && ex_wa!=0 && ex_wa matches a used source.
- Ready: in_ready = !hazard && (!out_valid || out_ready).
- Capture: when in_valid && in_ready && !flush, register pc, instr, resolved operands, immediate and rd. out_valid becomes 1 on the next edge.
- Drain: if out_valid && out_ready and no capture, out_valid becomes 0.
- Hold: while out_valid && !out_ready, all out_* stay stable (no bubble insertion, no overwrite).
- Immediate: I/S/B/U/J formats per RV32I, sign-extended to XLEN. R-type immediate is 0.
- out_rd: forced to 0 for STORE and BRANCH.
- flush:
  - Next edge sets out_valid=0.
  - An instruction offered in the same cycle is considered consumed by upstream (in_ready still reported) and is dropped.
  - flush dominates capture and hold.
- Simultaneous hazard and flush: flush wins; out_valid=0.
- Reset mid-stall: the stalled instruction is lost; upstream re-presents it.

Optional Feature:
- Macro: OPFETCH_BYPASS_EN.
- Defined: bypass paths as above.
- Undefined:
  - No EX/WB forwarding mux.
  - hazard is asserted whenever a used nonzero source matches ex_wa (ex_valid && ex_we) or wb_wa (wb_we).
  - Operands come from rd1/rd2 only, with x0 still forced to 0.

Decomposition:
- Shared package rv32_pkg:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
  - XLEN/NREG_BITS defaults.
  - Instruction field slice constants.
- Sub-module imm_gen: combinational, in_instr -> out_imm. Reusable by the execute stage.

Test Plan:
- Reset asserted mid-stream -> out_valid=0 immediately (no clock needed); after release, first accepted ADDI x1,x0,5 (0x00500093) -> out_op1=0, out_imm=5, out_rd=1 one cycle later.
- ADD x3,x1,x2 with ex_wa=1, ex_wd=0x11, wb_wa=2, wb_wd=0x22, rd1=rd2=0xDEAD -> out_op1=0x11, out_op2=0x22.
- EX and WB both target x1 (ex_wd=0xA, wb_wd=0xB) -> out_op1=0xA.
- Load-use: ex_is_load=1, ex_wa=5, incoming ADD x6,x5,x0 -> in_ready=0 for exactly the cycles ex_valid holds. With ex_valid dropped and wb_wa=5, wb_wd=0x77 -> accepted with out_op1=0x77.
- out_ready=0 for 3 cycles with out_valid=1 -> all out_* unchanged and in_ready=0. Raising out_ready with a new instruction pending -> back-to-back capture, out_valid stays 1.
- flush together with in_valid and in_ready -> next cycle out_valid=0, dropped instruction never appears. Repeat with OPFETCH_BYPASS_EN undefined -> the second scenario stalls until ex/wb no longer match.
